fifo_word_packer: RTL and testbench

- Downstream consumer of the 8-bit fifo.
- Pops bytes from the fifo read port and assembles them into BYTES_PER_WORD-byte words.
- Presents each word on a valid/ready output handshake to the next stage.
- Never reads an empty fifo, so the fifo's read-while-empty pointer-skip path is never exercised by this block. Supports a flush that emits a partial word.

---
 rtl/fifo_word_packer.sv | 181 ++++++++++++++++++
 tb/tb_fifo_word_packer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// Pops bytes from an 8-bit fifo and packs them into BYTES_PER_WORD-byte words on a valid/ready output.
// Optional macro PACKER_PARITY_EN adds a per-lane even-parity output registered with word_data.
module fifo_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int MAX_DATA       = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              fifo_empty,
  input  logic [7:0]                        fifo_rdata,
  output logic                              fifo_ren,
  input  logic                              flush,
  output logic [8*BYTES_PER_WORD-1:0]       word_data,
  output logic [$clog2(BYTES_PER_WORD):0]   word_bytes,
  output logic                              word_valid,
  input  logic                              word_ready
`ifdef PACKER_PARITY_EN
  ,
  output logic [BYTES_PER_WORD-1:0]         word_parity
`endif
);

  localparam int IW = $clog2(BYTES_PER_WORD) + 1;
  localparam logic [IW-1:0] FULL_CNT = IW'(BYTES_PER_WORD);

  if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8 || MAX_DATA < 1) begin : g_bad_cfg
    $error("fifo_word_packer: unsupported BYTES_PER_WORD or MAX_DATA");
  end

  typedef enum logic [1:0] {
    FILL  = 2'b00,
    DRAIN = 2'b01,
    STALL = 2'b10
  } state_t;

  function automatic logic [BYTES_PER_WORD-1:0] lane_parity(input logic [8*BYTES_PER_WORD-1:0] w);
    logic [BYTES_PER_WORD-1:0] p;
    p = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      p[i] = ^w[8*i +: 8];
    end
    return p;
  endfunction

  state_t                                state_q, state_d;
  logic [BYTES_PER_WORD-1:0][7:0]        buf_q, buf_d, asm_s;
  logic [IW-1:0]                         index_q, index_d, fill_cnt_s;
  logic                                  inflight_q, inflight_d;
  logic                                  run_q;
  logic [8*BYTES_PER_WORD-1:0]           data_q, data_d;
  logic [IW-1:0]                         bytes_q, bytes_d;
  logic                                  valid_q, valid_d;
  logic                                  ren_s, xfer_s, out_free_s, full_s, avail_s;
`ifdef PACKER_PARITY_EN
  logic [BYTES_PER_WORD-1:0]             parity_q, parity_d;
`endif

  // Next-state, capture, transfer and read-issue decisions.
  always_comb begin
    asm_s = buf_q;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (inflight_q && index_q == IW'(i)) begin
        asm_s[i] = fifo_rdata;
      end else begin
        asm_s[i] = buf_q[i];
      end
    end
    // fill_cnt_s counts the byte landing this cycle, so completion and transfer share its edge.
    fill_cnt_s = index_q + IW'(inflight_q);
    out_free_s = !valid_q || word_ready;
    full_s     = (fill_cnt_s == FULL_CNT);
    avail_s    = run_q && !fifo_empty;

    state_d    = state_q;
    buf_d      = asm_s;
    index_d    = fill_cnt_s;
    inflight_d = 1'b0;
    ren_s      = 1'b0;
    xfer_s     = 1'b0;

    case (state_q)
      FILL: begin
        if (full_s) begin
          if (out_free_s) begin
            xfer_s  = 1'b1;
            ren_s   = avail_s;
            state_d = (flush && ren_s) ? DRAIN : FILL;
          end else begin
            state_d = STALL;
          end
        end else begin
          ren_s = avail_s;
          if (flush && (fill_cnt_s != '0 || ren_s)) begin
            state_d = DRAIN;
          end else begin
            state_d = FILL;
          end
        end
        inflight_d = ren_s;
      end
      DRAIN, STALL: begin
        if (out_free_s) begin
          xfer_s  = 1'b1;
          state_d = FILL;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = FILL;
        buf_d   = '0;
        index_d = '0;
      end
    endcase

    if (xfer_s) begin
      buf_d   = '0;
      index_d = '0;
    end else begin
      index_d = index_d;
    end

    valid_d = valid_q;
    data_d  = data_q;
    bytes_d = bytes_q;
    if (xfer_s) begin
      valid_d = 1'b1;
      data_d  = asm_s;
      bytes_d = fill_cnt_s;
    end else if (word_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
`ifdef PACKER_PARITY_EN
    if (xfer_s) begin
      parity_d = lane_parity(asm_s);
    end else begin
      parity_d = parity_q;
    end
`endif
  end

  // Assembly, control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      buf_q      <= '0;
      index_q    <= '0;
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
      data_q     <= '0;
      bytes_q    <= '0;
      valid_q    <= 1'b0;
`ifdef PACKER_PARITY_EN
      parity_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      index_q    <= index_d;
      inflight_q <= inflight_d;
      run_q      <= 1'b1;
      data_q     <= data_d;
      bytes_q    <= bytes_d;
      valid_q    <= valid_d;
`ifdef PACKER_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign fifo_ren   = ren_s;
  assign word_data  = data_q;
  assign word_bytes = bytes_q;
  assign word_valid = valid_q;
`ifdef PACKER_PARITY_EN
  assign word_parity = parity_q;
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Randomized and directed bench for fifo_word_packer against a byte-stream reference model.
module tb_fifo_word_packer;
  localparam int BPW = 4;
  localparam int IW  = $clog2(BPW) + 1;
  localparam int W   = 8 * BPW;

  logic           clk;
  logic           rst_n;
  logic           fifo_empty;
  logic [7:0]     fifo_rdata;
  logic           fifo_ren;
  logic           flush;
  logic [W-1:0]   word_data;
  logic [IW-1:0]  word_bytes;
  logic           word_valid;
  logic           word_ready;
`ifdef PACKER_PARITY_EN
  logic [BPW-1:0] word_parity;
`endif

  fifo_word_packer #(.BYTES_PER_WORD(BPW), .MAX_DATA(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_ren   (fifo_ren),
    .flush      (flush),
    .word_data  (word_data),
    .word_bytes (word_bytes),
    .word_valid (word_valid),
    .word_ready (word_ready)
`ifdef PACKER_PARITY_EN
    ,
    .word_parity(word_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           nbytes;
  } word_t;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  fifo_q[$];
  logic [7:0]  cur_bytes[$];
  word_t       exp_q[$];
  int          ren_cnt, ren_run, max_ren_run, words_out, valid_cnt, cyc;
  int          first_ren_cyc, first_valid_cyc, ren_at_first_valid;
  int          flush_at_ren = -1;
  int          flush_pct = 0;
  int          push_pct = 0;
  bit          ready_rand = 1'b0;
  bit          ready_val = 1'b1;
  bit          flush_once = 1'b0;
  logic [7:0]  rdata_next;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BPW-1:0] exp_parity(input logic [W-1:0] d);
    logic [BPW-1:0] p;
    for (int i = 0; i < BPW; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

  // Close the current word: the bytes read since the last boundary, zero padded.
  task automatic model_emit();
    word_t w;
    if (cur_bytes.size() > 0) begin
      w.data = '0;
      foreach (cur_bytes[i]) w.data[8*i +: 8] = cur_bytes[i];
      w.nbytes = cur_bytes.size();
      exp_q.push_back(w);
      cur_bytes.delete();
    end
  endtask

  task automatic clear_counters();
    ren_cnt = 0; ren_run = 0; max_ren_run = 0; words_out = 0; valid_cnt = 0; cyc = 0;
    first_ren_cyc = -1; first_valid_cyc = -1; ren_at_first_valid = -1;
  endtask

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(first + 8'(i));
    fifo_empty = (fifo_q.size() == 0);
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic do_cycle();
    logic       ren_now;
    logic [7:0] b;
    cyc++;
    if (word_valid) begin
      valid_cnt++;
      if (first_valid_cyc < 0) begin
        first_valid_cyc    = cyc;
        ren_at_first_valid = ren_cnt;
      end
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 64'(word_valid), 64'd0);
      end else begin
        check_eq("word_data", 64'(word_data), 64'(exp_q[0].data));
        check_eq("word_bytes", 64'(word_bytes), 64'(exp_q[0].nbytes));
`ifdef PACKER_PARITY_EN
        check_eq("word_parity", 64'(word_parity), 64'(exp_parity(exp_q[0].data)));
`endif
      end
    end
    word_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    flush      = flush_once || (flush_pct > 0 && $urandom_range(0, 99) < flush_pct);
    flush_once = 1'b0;
    #1;
    check_eq("ren_while_empty", 64'(fifo_ren & fifo_empty), 64'd0);
    ren_now = fifo_ren;
    if (word_valid && word_ready) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      words_out++;
    end
    if (ren_now) begin
      ren_cnt++;
      ren_run++;
      if (first_ren_cyc < 0) first_ren_cyc = cyc;
      b = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'h00;
      rdata_next = b;
      cur_bytes.push_back(b);
      if (cur_bytes.size() == BPW) model_emit();
      if (flush_at_ren == ren_cnt) flush = 1'b1;
    end else begin
      ren_run = 0;
      rdata_next = 8'($urandom);
    end
    if (ren_run > max_ren_run) max_ren_run = ren_run;
    if (flush) model_emit();
    @(posedge clk);
    @(negedge clk);
    fifo_rdata = rdata_next;
    flush = 1'b0;
    if (push_pct > 0 && fifo_q.size() < 16 && $urandom_range(0, 99) < push_pct)
      fifo_q.push_back(8'($urandom));
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ren"}, 64'(fifo_ren), 64'd0);
    check_eq({tag, "_valid"}, 64'(word_valid), 64'd0);
    check_eq({tag, "_data"}, 64'(word_data), 64'd0);
    check_eq({tag, "_bytes"}, 64'(word_bytes), 64'd0);
`ifdef PACKER_PARITY_EN
    check_eq({tag, "_parity"}, 64'(word_parity), 64'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; word_ready = 1'b0; fifo_rdata = 8'h00; fifo_empty = 1'b1;
    clear_counters();
    @(negedge clk);
    load(8'h01, 8);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // streaming
    run(16);
    check_eq("stream_ren_cnt", 64'(ren_cnt), 64'd8);
    check_eq("stream_ren_run", 64'(max_ren_run), 64'd8);
    check_eq("stream_words", 64'(words_out), 64'd2);
    check_eq("stream_latency", 64'(first_valid_cyc - first_ren_cyc), 64'(BPW + 1));

    // backpressure
    clear_counters();
    load(8'h01, 8);
    ready_val = 1'b0;
    run(10);
    check_eq("bp_ren_cnt", 64'(ren_cnt), 64'd8);
    check_eq("bp_words_held", 64'(words_out), 64'd0);
    check_eq("bp_valid_held", 64'(word_valid), 64'd1);
    ready_val = 1'b1;
    run(8);
    check_eq("bp_words", 64'(words_out), 64'd2);

    // empty guard, then flush the partial word
    clear_counters();
    fifo_q.push_back(8'hAA); fifo_q.push_back(8'hBB); fifo_empty = 1'b0;
    run(10);
    check_eq("guard_ren_cnt", 64'(ren_cnt), 64'd2);
    check_eq("guard_no_valid", 64'(valid_cnt), 64'd0);
    flush_once = 1'b1;
    run(6);
    check_eq("flush_words", 64'(words_out), 64'd1);
    flush_once = 1'b1;
    run(6);
    check_eq("flush_noop_words", 64'(words_out), 64'd1);
    check_eq("flush_noop_valid", 64'(valid_cnt), 64'd1);

    // flush in the same cycle as the third read
    clear_counters();
    load(8'h21, 5);
    flush_at_ren = 3;
    run(8);
    flush_at_ren = -1;
    check_eq("inflight_reads_before_xfer", 64'(ren_at_first_valid), 64'd3);
    check_eq("inflight_words", 64'(words_out), 64'd1);
    flush_once = 1'b1;
    run(6);
    check_eq("inflight_tail_words", 64'(words_out), 64'd2);

    // randomized traffic, then drain
    clear_counters();
    ready_rand = 1'b1; push_pct = 50; flush_pct = 3;
    run(3000);
    ready_rand = 1'b0; ready_val = 1'b1; push_pct = 0; flush_pct = 0;
    run(40);
    flush_once = 1'b1;
    run(10);
    check_eq("rand_exp_left", 64'(exp_q.size()), 64'd0);
    check_eq("rand_cur_left", 64'(cur_bytes.size()), 64'd0);

    // reset in the middle of a word
    clear_counters();
    load(8'h55, 3);
    run(6);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    cur_bytes.delete();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_counters();
    load(8'h10, 4);
    run(12);
    check_eq("midreset_words", 64'(words_out), 64'd1);
    check_eq("midreset_ren_cnt", 64'(ren_cnt), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
